symbol_upsampler: RTL and testbench
===================================

Name: symbol_upsampler

Overview:
- AXI-Stream zero-insertion interpolator that sits directly upstream of fir_filter in the transmit pulse-shaping path.
- Each accepted input symbol produces UPSAMPLE_FACTOR output samples: the symbol itself, then UPSAMPLE_FACTOR-1 zeros.
- Frame boundaries carry through: tlast on an input symbol moves to the last sample of that symbol's output group, so fir_filter's tlast handling sees a complete upsampled frame.

Parameters:
- DATA_WIDTH, 16, sample width in and out; two's complement, passed through unchanged.
- UPSAMPLE_FACTOR, 4, output samples per input symbol; legal range 1..256.
- PHASE_WIDTH, derived localparam = max(1, $clog2(UPSAMPLE_FACTOR)), phase counter width.

Ports:
- clock  in  1  single block clock.
- reset  in  1  synchronous, active-high reset.
- data_in_tready  out  1  input symbol accepted this cycle when high with data_in_tvalid.
- data_in_tdata  in  DATA_WIDTH  input symbol.
- data_in_tlast  in  1  last symbol of frame.
- data_in_tvalid  in  1  input symbol valid.
- data_out_tready  in  1  downstream (fir_filter) ready.
- data_out_tdata  out  DATA_WIDTH  upsampled sample.
- data_out_tlast  out  1  last sample of frame.
- data_out_tvalid  out  1  output sample valid.
- busy  out  1  high while any output sample of the current symbol group is still undelivered.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high; ports named clock and reset.
- Reset values: data_out_tvalid=0, data_out_tlast=0, data_out_tdata=0, busy=0. Internal state: phase=0, last_pending=0.
- All outputs are registered. data_in_tready is combinational: (!data_out_tvalid) | (data_out_tready & phase==UPSAMPLE_FACTOR-1).
- Input handshake (data_in_tvalid & data_in_tready):
  - next cycle: data_out_tdata=data_in_tdata, data_out_tvalid=1, phase=0, last_pending=data_in_tlast;
  - data_out_tlast=data_in_tlast only when UPSAMPLE_FACTOR==1, else 0.
- Output handshake with phase<UPSAMPLE_FACTOR-1:
  - phase+1, data_out_tdata=0, data_out_tvalid stays 1;
  - data_out_tlast = last_pending & (phase+1==UPSAMPLE_FACTOR-1).
- Output handshake with phase==UPSAMPLE_FACTOR-1 and no new input: data_out_tvalid=0, data_out_tlast=0, last_pending=0.
- Simultaneous final-phase output handshake and input handshake: the new symbol loads directly, no bubble. Sustained throughput is one output sample per cycle.
- Latency: 1 cycle from input handshake to first output sample.
- Backpressure: data_out_tready low holds all output registers and phase stable (AXI rule: tvalid never drops without a handshake). data_in_tready is low during backpressure once the output is valid.
- data_in_tlast is ignored when the input handshake does not occur.
- Frame tlast asserts exactly once per input frame, on the final sample of the final group.
- busy = data_out_tvalid.
- Reset mid-group: the partial group is discarded, outputs return to reset values next cycle, and no tlast is emitted.

Optional Feature:
- Macro SYMBOL_UPSAMPLER_SAMPLE_HOLD_EN.
- Defined: phases 1..UPSAMPLE_FACTOR-1 repeat the held symbol (zero-order hold) instead of zero. A symbol register holds the value.
- Undefined: zero insertion as above; no symbol hold register is synthesised.
- Handshake, tlast and latency are identical in both builds.

Decomposition:
- Shared package dvb_modem_pkg:
  - AXI-Stream sample typedef (tdata/tlast/tvalid bundle);
  - clog2-with-minimum-1 function;
  - constant DEFAULT_UPSAMPLE_FACTOR=4, shared with the fir_filter instantiation wrapper.
- No sub-module: phase counter and output register are too tightly coupled to split.

Test Plan:
- UPSAMPLE_FACTOR=4, tready=1, inputs 100,200,300 back-to-back (300 tlast) -> outputs 100,0,0,0,200,0,0,0,300,0,0,0 on consecutive cycles; tlast only on the 12th; data_in_tready high on cycles 4 and 8 only after the first.
- Same stimulus with data_out_tready toggling 1,0,1,0 -> identical sample sequence; tdata/tvalid/tlast stable on every tready=0 cycle.
- UPSAMPLE_FACTOR=1, inputs 5,-7 (-7 tlast) -> outputs 5,-7 with latency 1; tlast on -7; throughput 1/cycle.
- Reset asserted after 2 of 4 output samples of symbol 42 with tlast -> next cycle tvalid=0, busy=0; no tlast emitted; next input 9 produces 9,0,0,0.
- SYMBOL_UPSAMPLER_SAMPLE_HOLD_EN defined, UPSAMPLE_FACTOR=3, input -32768 tlast -> outputs -32768,-32768,-32768; tlast on the 3rd.
- Input gap: symbol 1, then tvalid low for 6 cycles, then symbol 2 -> outputs 1,0,0,0; tvalid low during the gap; 2,0,0,0 starts 1 cycle after its handshake.

Source files
------------

// File: rtl/dvb_modem_pkg.sv
// Shared transmit-path types and helpers for the DVB modem blocks.
// Used by symbol_upsampler and the fir_filter instantiation wrapper.
package dvb_modem_pkg;

  localparam int DEFAULT_UPSAMPLE_FACTOR = 4;
  localparam int AXIS_DATA_W             = 16;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tlast;
    logic                   tvalid;
  } axis_sample_t;

  // Counter width that never collapses to zero bits for a factor of 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/symbol_upsampler.sv
// AXI-Stream zero-insertion interpolator feeding fir_filter; tlast moves to the group's last sample.
// Define SYMBOL_UPSAMPLER_SAMPLE_HOLD_EN to repeat the symbol (zero-order hold) instead of inserting zeros.
module symbol_upsampler
  import dvb_modem_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int UPSAMPLE_FACTOR = DEFAULT_UPSAMPLE_FACTOR
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  data_in_tready,
  input  logic [DATA_WIDTH-1:0] data_in_tdata,
  input  logic                  data_in_tlast,
  input  logic                  data_in_tvalid,
  input  logic                  data_out_tready,
  output logic [DATA_WIDTH-1:0] data_out_tdata,
  output logic                  data_out_tlast,
  output logic                  data_out_tvalid,
  output logic                  busy
);

  localparam int                     PHASE_WIDTH = clog2_min1(UPSAMPLE_FACTOR);
  localparam logic [PHASE_WIDTH-1:0] LAST_PHASE  = PHASE_WIDTH'(UPSAMPLE_FACTOR - 1);

  logic [PHASE_WIDTH-1:0] phase;
  logic [PHASE_WIDTH-1:0] next_phase;
  logic                   last_pending;
  logic                   final_phase;
  logic                   in_hs;
  logic                   out_hs;
  logic [DATA_WIDTH-1:0]  fill_data;

  assign final_phase    = (phase == LAST_PHASE);
  assign next_phase     = phase + PHASE_WIDTH'(1);
  // Accept a new symbol when idle or as the group's final sample leaves, so groups abut.
  assign data_in_tready = !data_out_tvalid | (data_out_tready & final_phase);
  assign in_hs          = data_in_tvalid & data_in_tready;
  assign out_hs         = data_out_tvalid & data_out_tready;
  assign busy           = data_out_tvalid;

`ifdef SYMBOL_UPSAMPLER_SAMPLE_HOLD_EN
  logic [DATA_WIDTH-1:0] symbol_q;

  always_ff @(posedge clock) begin
    if (reset)      symbol_q <= '0;
    else if (in_hs) symbol_q <= data_in_tdata;
  end

  assign fill_data = symbol_q;
`else
  assign fill_data = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_tdata  <= '0;
      data_out_tlast  <= 1'b0;
      data_out_tvalid <= 1'b0;
      phase           <= '0;
      last_pending    <= 1'b0;
    end else if (in_hs) begin
      data_out_tdata  <= data_in_tdata;
      data_out_tvalid <= 1'b1;
      data_out_tlast  <= (UPSAMPLE_FACTOR == 1) ? data_in_tlast : 1'b0;
      phase           <= '0;
      last_pending    <= data_in_tlast;
    end else if (out_hs) begin
      if (!final_phase) begin
        phase          <= next_phase;
        data_out_tdata <= fill_data;
        data_out_tlast <= last_pending & (next_phase == LAST_PHASE);
      end else begin
        // Group fully delivered and nothing queued behind it.
        data_out_tvalid <= 1'b0;
        data_out_tlast  <= 1'b0;
        last_pending    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_symbol_upsampler.sv
// Bench for symbol_upsampler: queue-based sample model checked every cycle, plus literal stream checks.
// Three instances: UPSAMPLE_FACTOR 4, 1 and 3.
module tb_symbol_upsampler;

  localparam int N = 3;
  localparam logic [N-1:0][8:0] UFP = {9'd3, 9'd1, 9'd4};

  typedef struct {
    int d;
    bit l;
  } samp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_data  [N];
  logic        in_last  [N];
  logic        in_valid [N];
  logic        in_rdy   [N];
  logic        out_rdy  [N];
  logic [15:0] out_data [N];
  logic        out_last [N];
  logic        out_valid[N];
  logic        busy     [N];

  samp_t q[N][$];
  int    log_d[N][$];
  bit    log_l[N][$];
  int    log_c[N][$];
  int    checks = 0, errors = 0, cyc = 0;
  bit    started = 0, toggle = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    symbol_upsampler #(.DATA_WIDTH(16), .UPSAMPLE_FACTOR(int'(UFP[g]))) dut (
      .clock          (clock),
      .reset          (reset),
      .data_in_tready (in_rdy[g]),
      .data_in_tdata  (in_data[g]),
      .data_in_tlast  (in_last[g]),
      .data_in_tvalid (in_valid[g]),
      .data_out_tready(out_rdy[g]),
      .data_out_tdata (out_data[g]),
      .data_out_tlast (out_last[g]),
      .data_out_tvalid(out_valid[g]),
      .busy           (busy[g])
    );
  end

  function automatic int fill(int sym);
`ifdef SYMBOL_UPSAMPLER_SAMPLE_HOLD_EN
    return sym;
`else
    return 0 * sym;
`endif
  endfunction

  task automatic chk(string n, int d, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d actual %0d required %0d", n, d, cyc, act, exp);
    end
  endtask

  // Model: the queue holds the undelivered samples of the current group.
  always @(posedge clock) begin
    bit    ohs, irdy;
    samp_t s;
    cyc++;
    for (int d = 0; d < N; d++) begin
      ohs  = q[d].size() != 0 && out_rdy[d];
      irdy = q[d].size() == 0 || (out_rdy[d] && q[d].size() == 1);
      if (reset) q[d].delete();
      else begin
        if (ohs) void'(q[d].pop_front());
        if (in_valid[d] && irdy)
          for (int k = 0; k < int'(UFP[d]); k++) begin
            s.d = (k == 0) ? int'($signed(in_data[d])) : fill(int'($signed(in_data[d])));
            s.l = in_last[d] && (k == int'(UFP[d]) - 1);
            q[d].push_back(s);
          end
      end
    end
  end

  always @(negedge clock) begin
    bit ev, er;
    if (started)
      for (int d = 0; d < N; d++) begin
        ev = q[d].size() != 0;
        er = q[d].size() == 0 || (out_rdy[d] && q[d].size() == 1);
        chk("tvalid", d, out_valid[d], ev);
        chk("busy", d, busy[d], ev);
        chk("in_tready", d, in_rdy[d], er);
        if (ev) begin
          chk("tdata", d, $signed(out_data[d]), q[d][0].d);
          chk("tlast", d, out_last[d], q[d][0].l);
        end
        if (out_valid[d] === 1'b1 && out_rdy[d]) begin
          log_d[d].push_back(int'($signed(out_data[d])));
          log_l[d].push_back(out_last[d]);
          log_c[d].push_back(cyc);
        end
      end
  end

  always @(posedge clock) begin
    #1;
    if (toggle) out_rdy[0] = !out_rdy[0];
  end

  task automatic clear_logs();
    for (int d = 0; d < N; d++) begin
      log_d[d].delete();
      log_l[d].delete();
      log_c[d].delete();
    end
  endtask

  task automatic send(int d, int v, bit l);
    int n;
    bit ok;
    n = 0;
    in_data[d] = 16'(v);
    in_last[d] = l;
    in_valid[d] = 1'b1;
    do begin
      @(negedge clock);
      ok = in_rdy[d];
      @(posedge clock);
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", d, n, 0);
    #1 in_valid[d] = 1'b0;
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    while (q[d].size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("drain_timeout", d, n, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic check_log(int d, string n, int exp[$], int tl_idx, bit consec);
    chk({n, "_len"}, d, log_d[d].size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_d[d].size(); i++) begin
      chk({n, "_data"}, d, log_d[d][i], exp[i]);
      chk({n, "_tlast"}, d, log_l[d][i], (i == tl_idx));
      if (consec && i > 0) chk({n, "_cycle_gap"}, d, log_c[d][i] - log_c[d][i-1], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e[$];
    int tl_count;
    reset = 1'b1;
    for (int d = 0; d < N; d++) begin
      in_data[d] = '0; in_last[d] = 1'b0; in_valid[d] = 1'b0; out_rdy[d] = 1'b1;
    end
    @(posedge clock);
    #1 started = 1;
    @(negedge clock);
    chk("reset_tvalid", 0, out_valid[0], 0);
    chk("reset_tdata", 0, out_data[0], 0);
    chk("reset_busy", 0, busy[0], 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Back-to-back symbols, full throughput.
    clear_logs();
    send(0, 100, 0); send(0, 200, 0); send(0, 300, 1);
    drain(0);
    e = {100, fill(100), fill(100), fill(100), 200, fill(200), fill(200), fill(200),
         300, fill(300), fill(300), fill(300)};
    check_log(0, "b2b", e, 11, 1);

    // Same stimulus under alternating backpressure.
    clear_logs();
    toggle = 1;
    send(0, 100, 0); send(0, 200, 0); send(0, 300, 1);
    drain(0);
    toggle = 0;
    out_rdy[0] = 1'b1;
    @(posedge clock); #1;
    check_log(0, "bp", e, 11, 0);

    // Factor 1: pass-through with tlast.
    clear_logs();
    send(1, 5, 0); send(1, -7, 1);
    drain(1);
    e = {5, -7};
    check_log(1, "uf1", e, 1, 1);

    // Reset after two of four samples of a tlast symbol.
    clear_logs();
    send(0, 42, 1);
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_tvalid", 0, out_valid[0], 0);
    chk("midrst_busy", 0, busy[0], 0);
    tl_count = 0;
    foreach (log_l[0][i]) tl_count += int'(log_l[0][i]);
    chk("midrst_no_tlast", 0, tl_count, 0);
    clear_logs();
    @(posedge clock); #1;
    send(0, 9, 0);
    drain(0);
    e = {9, fill(9), fill(9), fill(9)};
    check_log(0, "after_rst", e, -1, 1);

    // Factor 3, full-scale negative symbol.
    clear_logs();
    send(2, -32768, 1);
    drain(2);
    e = {-32768, fill(-32768), fill(-32768)};
    check_log(2, "uf3", e, 2, 1);

    // Input gap between two symbols.
    clear_logs();
    send(0, 1, 0);
    repeat (6) @(posedge clock);
    #1;
    send(0, 2, 0);
    drain(0);
    e = {1, fill(1), fill(1), fill(1), 2, fill(2), fill(2), fill(2)};
    check_log(0, "gap", e, -1, 0);
    if (log_c[0].size() == 8) chk("gap_restart", 0, log_c[0][4] - log_c[0][3], 4);
    else chk("gap_count", 0, log_c[0].size(), 8);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
